pc_gen: RTL and testbench

Parametrised fetch-PC generator for the RISC-V core front end. It is the next generation of the single-width program counter. It adds configurable address width, reset vector, increment and stall-vector width, and two-source prioritised redirects (trap over branch). Redirects that arrive during a stall are captured and held, not dropped, and a valid/ready handshake drives instruction fetch. It sits between the pipeline control and stall unit and the instruction-memory fetch port.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_redir_hold.sv | 60 ++++++
 rtl/pc_gen.sv | 180 ++++++++++++++++++
 tb/tb_pc_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and defaults for the fetch-PC generator.
//   state_e  - PC stage state machine encoding
//   pri_e    - priority tag of a captured redirect (branch < trap)
//   DEF_*    - default reset vector and sequential increment
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic {
    PRI_BR   = 1'b0,
    PRI_TRAP = 1'b1
  } pri_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam int unsigned DEF_INC       = 4;

endpackage

// File: rtl/pc_redir_hold.sv
// pc_redir_hold: pending redirect register for the fetch-PC generator.
// Holds one redirect target plus its priority while the PC stage is stalled.
// A trap always overwrites; a branch overwrites only a pending branch.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   capture             load a fresh redirect (trap over branch), ignoring contents
//   merge               fold this cycle's requests into the held entry
//   clear               drop the held entry (redirect has been issued)
//   trap/trap_addr      trap request and target
//   br/br_addr          branch request and target
//   merged_tgt          held target with this cycle's requests folded in
module pc_redir_hold
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              merge,
  input  logic              clear,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] merged_tgt
);

  logic [ADDR_W-1:0] tgt_q;
  pri_e              pri_q;
  pri_e              merged_pri;

  always_comb begin
    merged_tgt = tgt_q;
    merged_pri = pri_q;
    if (trap) begin
      merged_tgt = trap_addr;
      merged_pri = PRI_TRAP;
    end else if (br && (pri_q == PRI_BR)) begin
      merged_tgt = br_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q <= '0;
      pri_q <= PRI_BR;
    end else if (clear) begin
      tgt_q <= '0;
      pri_q <= PRI_BR;
    end else if (capture) begin
      tgt_q <= trap ? trap_addr : br_addr;
      pri_q <= trap ? PRI_TRAP : PRI_BR;
    end else if (merge) begin
      tgt_q <= merged_tgt;
      pri_q <= merged_pri;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-PC generator for the core front end.
// Issues sequential fetch PCs over a valid/ready handshake, applies trap and
// branch redirects (trap wins), and holds redirects that arrive while the PC
// stage is stalled until the stall clears.
// Optional build macro PC_GEN_MISALIGN_EN adds misalign_o: a redirect to a
// target not aligned to INC pulses misalign_o and suppresses pc_valid_o for
// that cycle (the target is still loaded).
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   stall                  pipeline stall vector; bit STALL_IDX freezes this stage
//   trap_i, trap_addr_i    trap redirect request and target (highest priority)
//   br, br_addr            branch redirect request and target
//   if_ready_i             fetch port accepts pc_o this cycle
//   pc_o, pc_valid_o       registered fetch PC and its valid
//   right_one_o            pc_o is a freshly loaded redirect target (one cycle)
//   redir_pend_o           a redirect is held waiting for the stall to clear
//   misalign_o             (PC_GEN_MISALIGN_EN only) misaligned redirect applied
//
// state | meaning
// BOOT  | first cycle after reset, pc_o = RESET_VEC not yet valid
// RUN   | issuing fetches, redirects applied directly
// HOLD  | stalled with a captured redirect waiting
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int unsigned       INC       = DEF_INC,
  parameter int                STALL_W   = 6,
  parameter int                STALL_IDX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               trap_i,
  input  logic [ADDR_W-1:0]  trap_addr_i,
  input  logic               br,
  input  logic [ADDR_W-1:0]  br_addr,
  input  logic               if_ready_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               pc_valid_o,
  output logic               right_one_o,
`ifdef PC_GEN_MISALIGN_EN
  output logic               misalign_o,
`endif
  output logic               redir_pend_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              right_q, right_d;
  logic              pend_q, pend_d;
  logic              hold_capture, hold_merge, hold_clear;
  logic [ADDR_W-1:0] pend_tgt;

  logic              stl, adv, req;
  logic [ADDR_W-1:0] tgt;

  // Only one bit of the stall vector matters to this stage.
  logic stall_unused;
  assign stall_unused = ^stall;

  assign stl = stall[STALL_IDX];
  assign adv = valid_q & if_ready_i & ~stl;
  assign req = trap_i | br;
  assign tgt = trap_i ? trap_addr_i : br_addr;

`ifdef PC_GEN_MISALIGN_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);
  logic mis_q, mis_d;
`endif

  pc_redir_hold #(.ADDR_W(ADDR_W)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .capture    (hold_capture),
    .merge      (hold_merge),
    .clear      (hold_clear),
    .trap       (trap_i),
    .trap_addr  (trap_addr_i),
    .br         (br),
    .br_addr    (br_addr),
    .merged_tgt (pend_tgt)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    right_d      = 1'b0;
    pend_d       = pend_q;
    hold_capture = 1'b0;
    hold_merge   = 1'b0;
    hold_clear   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        if (req && !stl) begin
          // Applied even without if_ready_i: the outstanding fetch is squashed.
          pc_d    = tgt;
          right_d = 1'b1;
          valid_d = 1'b1;
        end else if (req) begin
          hold_capture = 1'b1;
          state_d      = HOLD;
          pend_d       = 1'b1;
          valid_d      = 1'b0;
        end else begin
          valid_d = 1'b1;
          if (adv) pc_d = pc_q + ADDR_W'(INC);
        end
      end
      HOLD: begin
        if (stl) begin
          hold_merge = 1'b1;
        end else begin
          pc_d       = pend_tgt;
          right_d    = 1'b1;
          valid_d    = 1'b1;
          pend_d     = 1'b0;
          hold_clear = 1'b1;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

`ifdef PC_GEN_MISALIGN_EN
  logic valid_chk;
  always_comb begin
    mis_d     = 1'b0;
    valid_chk = valid_d;
    if (right_d && ((pc_d & ALIGN_MASK) != '0)) begin
      mis_d     = 1'b1;
      valid_chk = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign misalign_o = mis_q;
`else
  logic valid_chk;
  assign valid_chk = valid_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      right_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_chk;
      right_q <= right_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_valid_o   = valid_q;
  assign right_one_o  = right_q;
  assign redir_pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_addr_i = '0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        if_ready_i = 1'b1;

  logic [31:0] pc_o;
  logic        pc_valid_o, right_one_o, redir_pend_o;
  logic [31:0] pc_w;
  logic        valid_w, right_w, pend_w;
`ifdef PC_GEN_MISALIGN_EN
  logic        mis_a, mis_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .trap_i(trap_i), .trap_addr_i(trap_addr_i),
    .br(br), .br_addr(br_addr), .if_ready_i(if_ready_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .right_one_o(right_one_o),
`ifdef PC_GEN_MISALIGN_EN
    .misalign_o(mis_a),
`endif
    .redir_pend_o(redir_pend_o)
  );

  // Wrap-around instance: free-running from the top of the address space.
  pc_gen #(.RESET_VEC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall(6'd0), .trap_i(1'b0), .trap_addr_i(32'd0),
    .br(1'b0), .br_addr(32'd0), .if_ready_i(1'b1),
    .pc_o(pc_w), .pc_valid_o(valid_w), .right_one_o(right_w),
`ifdef PC_GEN_MISALIGN_EN
    .misalign_o(mis_b),
`endif
    .redir_pend_o(pend_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending slot (target + is-trap flag) plus the issued PC.
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0, m_right = 1'b0, m_live = 1'b0, m_hold = 1'b0;
  logic [31:0] p_tgt = '0;
  logic        p_trap = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 32'h0; m_valid <= 1'b0; m_right <= 1'b0;
      m_live <= 1'b0; m_hold <= 1'b0; p_tgt <= '0; p_trap <= 1'b0;
    end else begin : upd
      logic [31:0] npc, ntgt;
      logic nvalid, nright, nhold, ntrap, stalled;
      npc = m_pc; nvalid = m_valid; nright = 1'b0; nhold = m_hold;
      ntgt = p_tgt; ntrap = p_trap; stalled = stall[0];
      if (!m_live) begin
        nvalid = 1'b1;
      end else if (m_hold) begin
        if (trap_i) begin ntgt = trap_addr_i; ntrap = 1'b1; end
        else if (br && !p_trap) ntgt = br_addr;
        if (!stalled) begin
          npc = ntgt; nright = 1'b1; nvalid = 1'b1; nhold = 1'b0;
        end
      end else if (trap_i || br) begin
        if (!stalled) begin
          npc = trap_i ? trap_addr_i : br_addr; nright = 1'b1; nvalid = 1'b1;
        end else begin
          ntgt = trap_i ? trap_addr_i : br_addr; ntrap = trap_i;
          nhold = 1'b1; nvalid = 1'b0;
        end
      end else begin
        if (m_valid && if_ready_i && !stalled) npc = m_pc + 32'd4;
        nvalid = 1'b1;
      end
      m_live <= 1'b1; m_pc <= npc; m_valid <= nvalid; m_right <= nright;
      m_hold <= nhold; p_tgt <= ntgt; p_trap <= ntrap;
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_pc", pc_o, m_pc);
      check("model_valid", {31'd0, pc_valid_o}, {31'd0, m_valid});
      check("model_right", {31'd0, right_one_o}, {31'd0, m_right});
      check("model_pend", {31'd0, redir_pend_o}, {31'd0, m_hold});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    cyc(); cyc();
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'd0, pc_valid_o}, 32'd0);
    check("rst_pend", {31'd0, redir_pend_o}, 32'd0);
    check("rst_right", {31'd0, right_one_o}, 32'd0);
    rst = 1'b1;
    cyc();
    check("boot_pc", pc_o, 32'h0);
    check("boot_valid", {31'd0, pc_valid_o}, 32'd1);
    check("wrap_boot_pc", pc_w, 32'hFFFF_FFFC);
    check("wrap_boot_valid", {31'd0, valid_w}, 32'd1);
    cyc();
    check("seq_pc4", pc_o, 32'h4);
    check("wrap_pc0", pc_w, 32'h0);
    check("wrap_flags", {30'd0, right_w, pend_w}, 32'd0);
    cyc();
    check("seq_pc8", pc_o, 32'h8);
    if_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_hold", pc_o, 32'h8);
    end
    if_ready_i = 1'b1;
    cyc();
    check("bp_resume", pc_o, 32'hC);
    cyc();
    check("seq_pc10", pc_o, 32'h10);
    br = 1'b1; br_addr = 32'h100;
    cyc();
    check("br_pc", pc_o, 32'h100);
    check("br_right", {31'd0, right_one_o}, 32'd1);
    br = 1'b0;
    cyc();
    check("br_next", pc_o, 32'h104);
    check("br_right_clr", {31'd0, right_one_o}, 32'd0);
    // Stalled conflict: branch, then trap, then a later branch.
    stall = 6'd1; br = 1'b1; br_addr = 32'h200;
    cyc();
    check("stl_pend1", {31'd0, redir_pend_o}, 32'd1);
    check("stl_valid1", {31'd0, pc_valid_o}, 32'd0);
    br = 1'b0; trap_i = 1'b1; trap_addr_i = 32'h80;
    cyc();
    check("stl_pend2", {31'd0, redir_pend_o}, 32'd1);
    trap_i = 1'b0; br = 1'b1; br_addr = 32'h300;
    cyc();
    check("stl_valid3", {31'd0, pc_valid_o}, 32'd0);
    check("stl_pc_held", pc_o, 32'h104);
    br = 1'b0;
    cyc();
    stall = 6'd0;
    cyc();
    check("rel_pc", pc_o, 32'h80);
    check("rel_right", {31'd0, right_one_o}, 32'd1);
    check("rel_pend", {31'd0, redir_pend_o}, 32'd0);
    cyc();
    check("rel_next", pc_o, 32'h84);
    // Simultaneous trap and branch while running.
    trap_i = 1'b1; trap_addr_i = 32'h40; br = 1'b1; br_addr = 32'h500;
    cyc();
    check("both_pc", pc_o, 32'h40);
    trap_i = 1'b0; br = 1'b0;
    cyc();
    check("both_next", pc_o, 32'h44);
    // Pending trap vs. branch arriving on the release cycle.
    stall = 6'd1; trap_i = 1'b1; trap_addr_i = 32'h60;
    cyc();
    trap_i = 1'b0; stall = 6'd0; br = 1'b1; br_addr = 32'h700;
    cyc();
    check("pri_rel_pc", pc_o, 32'h60);
    br = 1'b0;
    cyc();
    check("pri_rel_next", pc_o, 32'h64);
    // Reset while holding a redirect.
    stall = 6'd1; br = 1'b1; br_addr = 32'h200;
    cyc();
    check("rh_pend", {31'd0, redir_pend_o}, 32'd1);
    br = 1'b0; rst = 1'b0;
    #1;
    check("rh_rst_pc", pc_o, 32'h0);
    check("rh_rst_pend", {31'd0, redir_pend_o}, 32'd0);
    cyc();
    rst = 1'b1; stall = 6'd0;
    cyc();
    check("rh_boot_pc", pc_o, 32'h0);
    check("rh_boot_right", {31'd0, right_one_o}, 32'd0);
    cyc();
    check("rh_pc4", pc_o, 32'h4);
    cyc();
    check("rh_pc8", pc_o, 32'h8);
    cyc();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
